// File: rtl/wb_stage_if.sv
// Writeback stage bundle: execute handshake, load response,
// and the register-file write port with error pulses.
interface wb_stage_if #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
);
   logic                  in_valid;
   logic                  in_ready;
   logic [REG_ADDR_W-1:0] in_rd_addr;
   logic                  in_rd_we;
   logic                  in_is_load;
   logic [2:0]            in_funct3;
   logic [XLEN-1:0]       in_result;
   logic                  mem_rsp_valid;
   logic [XLEN-1:0]       mem_rsp_data;
   logic                  wb_write_en;
   logic [REG_ADDR_W-1:0] wb_rd_addr;
   logic [XLEN-1:0]       wb_write_data;
   logic                  err_misaligned;
   logic                  err_timeout;

   modport master (
      output in_valid, in_rd_addr, in_rd_we, in_is_load,
      output in_funct3, in_result, mem_rsp_valid, mem_rsp_data,
      input  in_ready, wb_write_en, wb_rd_addr, wb_write_data,
      input  err_misaligned, err_timeout
   );

   modport slave (
      input  in_valid, in_rd_addr, in_rd_we, in_is_load,
      input  in_funct3, in_result, mem_rsp_valid, mem_rsp_data,
      output in_ready, wb_write_en, wb_rd_addr, wb_write_data,
      output err_misaligned, err_timeout
   );
endinterface

// File: rtl/wb_stage.sv
// RV32I writeback stage: retires one instruction per cycle,
// waits for load data, aligns/extends it, drives the RF port.
module wb_stage #(
   parameter int XLEN        = 32,
   parameter int REG_ADDR_W  = 5,
   parameter int MEM_TIMEOUT = 16
) (
   input logic        clk,
   input logic        rst_n,
   wb_stage_if.slave  bus
);
   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MEM_TIMEOUT - 1);

   typedef enum logic {IDLE, WAIT_MEM} state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q;
   logic [REG_ADDR_W-1:0] h_rd_q;
   logic                  h_we_q;
   logic [2:0]            h_f3_q;
   logic [1:0]            h_off_q;

   logic                  accept;
   logic                  ld_bad;
   logic                  cnt_hit;
   logic [7:0]            ld_b;
   logic [15:0]           ld_h;
   logic                  ld_sx;
   logic [XLEN-1:0]       ld_data;

   assign accept  = bus.in_valid && bus.in_ready;
   assign cnt_hit = (cnt_q == CNT_LIM);

   // Reject illegal funct3 and misaligned halfword/word loads
   always_comb begin
      ld_bad = 1'b1;
      case (bus.in_funct3)
         3'b000, 3'b100: ld_bad = 1'b0;
         3'b001, 3'b101: ld_bad = bus.in_result[0];
         3'b010:         ld_bad = |bus.in_result[1:0];
         default:        ld_bad = 1'b1;
      endcase
   end

   // Select the addressed byte/halfword and extend it
   always_comb begin
      ld_b    = bus.mem_rsp_data[8*h_off_q +: 8];
      ld_h    = h_off_q[1] ? bus.mem_rsp_data[31:16]
                           : bus.mem_rsp_data[15:0];
      ld_sx   = ~h_f3_q[2];
      ld_data = bus.mem_rsp_data;
      unique case (1'b1)
         (h_f3_q[1:0] == 2'b00):
            ld_data = {{(XLEN-8){ld_sx & ld_b[7]}}, ld_b};
         (h_f3_q[1:0] == 2'b01):
            ld_data = {{(XLEN-16){ld_sx & ld_h[15]}}, ld_h};
         default:
            ld_data = bus.mem_rsp_data;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:
            if (accept && bus.in_is_load && !ld_bad)
               state_d = WAIT_MEM;
         WAIT_MEM:
            if (bus.mem_rsp_valid || cnt_hit)
               state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake output: accept only while idle
   always_comb begin
      bus.in_ready = (state_q == IDLE);
   end

   // Registered RF write, error pulses, load context and timeout
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.wb_write_en    <= 1'b0;
         bus.wb_rd_addr     <= '0;
         bus.wb_write_data  <= '0;
         bus.err_misaligned <= 1'b0;
         bus.err_timeout    <= 1'b0;
         cnt_q              <= '0;
         h_rd_q             <= '0;
         h_we_q             <= 1'b0;
         h_f3_q             <= '0;
         h_off_q            <= '0;
      end else begin
         bus.wb_write_en    <= 1'b0;
         bus.err_misaligned <= 1'b0;
         bus.err_timeout    <= 1'b0;
         if (state_q == IDLE) begin
            if (accept && !bus.in_is_load) begin
               if (bus.in_rd_we && (bus.in_rd_addr != '0)) begin
                  bus.wb_write_en   <= 1'b1;
                  bus.wb_rd_addr    <= bus.in_rd_addr;
                  bus.wb_write_data <= bus.in_result;
               end
            end else if (accept && ld_bad) begin
               bus.err_misaligned <= 1'b1;
            end else if (accept) begin
               h_rd_q  <= bus.in_rd_addr;
               h_we_q  <= bus.in_rd_we;
               h_f3_q  <= bus.in_funct3;
               h_off_q <= bus.in_result[1:0];
               cnt_q   <= '0;
            end
         end else begin
            if (bus.mem_rsp_valid) begin
               cnt_q <= '0;
               if (h_we_q && (h_rd_q != '0)) begin
                  bus.wb_write_en   <= 1'b1;
                  bus.wb_rd_addr    <= h_rd_q;
                  bus.wb_write_data <= ld_data;
               end
            end else if (cnt_hit) begin
               cnt_q           <= '0;
               bus.err_timeout <= 1'b1;
            end else begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes expected RF
// writes/errors, a negedge monitor pops and compares them.
module tb_wb_stage;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   typedef struct {
      int          kind;
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   exp_t q[$];

   wb_stage_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

   wb_stage #(.XLEN(32), .REG_ADDR_W(5), .MEM_TIMEOUT(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Monitor: every output event must match the head of the queue
   always @(negedge clk) begin
      logic [2:0] act;
      logic [2:0] req;
      exp_t e;
      act = {bus.wb_write_en, bus.err_misaligned, bus.err_timeout};
      if (act != 3'b000) begin
         n_tests++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got we/mis/to=%b, required none",
                     act);
         end else begin
            e = q.pop_front();
            req = (e.kind == 0) ? 3'b100 : (e.kind == 1) ? 3'b010 : 3'b001;
            if (act !== req) begin
               n_fail++;
               $display("FAIL event_kind: got we/mis/to=%b, required %b",
                        act, req);
            end else if (e.kind == 0 && (bus.wb_rd_addr !== e.rd ||
                         bus.wb_write_data !== e.data)) begin
               n_fail++;
               $display("FAIL write: got rd=%0d data=%h, required rd=%0d data=%h",
                        bus.wb_rd_addr, bus.wb_write_data, e.rd, e.data);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int kind, input logic [4:0] rd,
                       input logic [31:0] data);
      exp_t e;
      e.kind = kind;
      e.rd   = rd;
      e.data = data;
      q.push_back(e);
   endtask

   task automatic issue(input logic [4:0] rd, input logic we,
                        input logic ld, input logic [2:0] f3,
                        input logic [31:0] res);
      bus.in_valid   = 1'b1;
      bus.in_rd_addr = rd;
      bus.in_rd_we   = we;
      bus.in_is_load = ld;
      bus.in_funct3  = f3;
      bus.in_result  = res;
      step();
      bus.in_valid   = 1'b0;
   endtask

   task automatic respond(input logic [31:0] d);
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = d;
      step();
      bus.mem_rsp_valid = 1'b0;
   endtask

   task automatic do_load(input logic [4:0] rd, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rsp,
                          input int dly, input logic [31:0] req);
      push(0, rd, req);
      issue(rd, 1'b1, 1'b1, f3, addr);
      for (int i = 0; i < dly; i++) begin
         chk("ready_wait", {31'd0, bus.in_ready}, 32'd0);
         step();
      end
      chk("ready_rsp_cycle", {31'd0, bus.in_ready}, 32'd0);
      respond(rsp);
      chk("ready_after_load", {31'd0, bus.in_ready}, 32'd1);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_we", {31'd0, bus.wb_write_en}, 32'd0);
      chk("rst_rd", {27'd0, bus.wb_rd_addr}, 32'd0);
      chk("rst_data", bus.wb_write_data, 32'd0);
      chk("rst_mis", {31'd0, bus.err_misaligned}, 32'd0);
      chk("rst_to", {31'd0, bus.err_timeout}, 32'd0);
      chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);
   endtask

   typedef struct {
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] rsp;
      logic [31:0] req;
   } ld_vec_t;

   ld_vec_t lv[6];

   initial begin
      lv[0] = '{5'd7,  3'b000, 32'h0000_1003, 32'h80FF_1234, 32'hFFFF_FF80};
      lv[1] = '{5'd8,  3'b101, 32'h0000_1002, 32'h8001_7FFF, 32'h0000_8001};
      lv[2] = '{5'd9,  3'b001, 32'h0000_1000, 32'h8001_7FFF, 32'h0000_7FFF};
      lv[3] = '{5'd10, 3'b001, 32'h0000_1002, 32'h8001_7FFF, 32'hFFFF_8001};
      lv[4] = '{5'd11, 3'b100, 32'h0000_1001, 32'h80FF_1234, 32'h0000_0012};
      lv[5] = '{5'd12, 3'b010, 32'h0000_1004, 32'hCAFE_BABE, 32'hCAFE_BABE};

      bus.in_valid      = 1'b0;
      bus.in_rd_addr    = '0;
      bus.in_rd_we      = 1'b0;
      bus.in_is_load    = 1'b0;
      bus.in_funct3     = '0;
      bus.in_result     = '0;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = '0;

      repeat (3) step();
      chk_reset_outputs();
      rst_n = 1'b1;
      step();

      push(0, 5'd5, 32'h1234_5678);
      issue(5'd5, 1'b1, 1'b0, 3'b000, 32'h1234_5678);
      issue(5'd0, 1'b1, 1'b0, 3'b000, 32'hDEAD_BEEF);
      chk("hold_rd", {27'd0, bus.wb_rd_addr}, 32'd5);
      chk("hold_data", bus.wb_write_data, 32'h1234_5678);
      step();

      for (int i = 0; i < 6; i++)
         do_load(lv[i].rd, lv[i].f3, lv[i].addr, lv[i].rsp, 0, lv[i].req);

      for (int i = 1; i <= 4; i++) begin
         push(0, 5'(i), 32'hA000_0000 + 32'(i));
         issue(5'(i), 1'b1, 1'b0, 3'b000, 32'hA000_0000 + 32'(i));
         chk("b2b_ready", {31'd0, bus.in_ready}, 32'd1);
      end
      do_load(5'd13, 3'b000, 32'h0000_3000, 32'h0000_00F5, 3,
              32'hFFFF_FFF5);

      push(1, 5'd0, 32'd0);
      issue(5'd14, 1'b1, 1'b1, 3'b010, 32'h0000_2002);
      chk("mis_ready_lw", {31'd0, bus.in_ready}, 32'd1);
      push(1, 5'd0, 32'd0);
      issue(5'd14, 1'b1, 1'b1, 3'b110, 32'h0000_2000);
      chk("mis_ready_f3", {31'd0, bus.in_ready}, 32'd1);
      push(1, 5'd0, 32'd0);
      issue(5'd14, 1'b1, 1'b1, 3'b001, 32'h0000_2001);
      step();

      push(2, 5'd0, 32'd0);
      issue(5'd15, 1'b1, 1'b1, 3'b010, 32'h0000_4000);
      for (int i = 0; i < 15; i++) begin
         chk("to_wait_ready", {31'd0, bus.in_ready}, 32'd0);
         step();
      end
      chk("to_pre_err", {31'd0, bus.err_timeout}, 32'd0);
      step();
      chk("to_err", {31'd0, bus.err_timeout}, 32'd1);
      chk("to_ready", {31'd0, bus.in_ready}, 32'd1);
      respond(32'h1111_1111);
      step();

      do_load(5'd16, 3'b010, 32'h0000_4000, 32'h5555_AAAA, 15,
              32'h5555_AAAA);
      step();

      issue(5'd17, 1'b1, 1'b1, 3'b010, 32'h0000_5000);
      step();
      rst_n = 1'b0;
      step();
      chk_reset_outputs();
      rst_n = 1'b1;
      respond(32'h7777_7777);
      step();

      push(0, 5'd18, 32'h0BAD_F00D);
      issue(5'd18, 1'b1, 1'b0, 3'b000, 32'h0BAD_F00D);
      repeat (3) step();

      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the RV32I pipeline. Sits directly upstream of the architectural register file and drives its write_en, rd_addr and write_data inputs.
- Accepts one retiring instruction per cycle from execute through a valid/ready handshake.
- For loads, it waits for the data-memory response, then aligns and sign- or zero-extends the data.
- Emits at most one registered register-file write per retired instruction.

Parameters:
- XLEN, 32, data width.
- REG_ADDR_W, 5, register address width.
- MEM_TIMEOUT, 16, maximum number of cycles spent waiting for a load response before aborting (minimum 1).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  execute presents an instruction
- in_ready  output  1  stage can accept (high only in IDLE)
- in_rd_addr  input  REG_ADDR_W  destination register
- in_rd_we  input  1  instruction writes rd
- in_is_load  input  1  instruction is a load
- in_funct3  input  3  load type (LB 000, LH 001, LW 010, LBU 100, LHU 101)
- in_result  input  XLEN  ALU result; for loads, the effective byte address
- mem_rsp_valid  input  1  load data valid (single-cycle pulse)
- mem_rsp_data  input  XLEN  naturally aligned 32-bit word containing the load
- wb_write_en  output  1  register-file write strobe
- wb_rd_addr  output  REG_ADDR_W  register-file destination
- wb_write_data  output  XLEN  register-file write data
- err_misaligned  output  1  one-cycle pulse: misaligned or illegal-funct3 load
- err_timeout  output  1  one-cycle pulse: load response timed out

Behaviour:
- Reset (rst_n low at a clk edge, synchronous, active-low):
  - state goes to IDLE and the timeout counter clears.
  - All outputs clear to 0 except in_ready, which is 1.
  - A reset during WAIT_MEM discards the pending load with no write and no error.
- Acceptance: an instruction is accepted when in_valid && in_ready at a rising edge; inputs are captured at that edge.
- States: IDLE, WAIT_MEM.
- IDLE, non-load accept (in_is_load=0):
  - The following cycle, wb_write_en = in_rd_we && (in_rd_addr != 0), wb_rd_addr = in_rd_addr, wb_write_data = in_result.
  - Latency is 1; the state stays IDLE, so a new instruction can be accepted every cycle.
- IDLE, load accept:
  - If funct3 is 011/110/111, or LH/LHU with addr[0]=1, or LW with addr[1:0]!=0: pulse err_misaligned the next cycle, do not write, stay in IDLE.
  - Otherwise go to WAIT_MEM, holding rd, we, funct3 and addr[1:0].
- WAIT_MEM:
  - in_ready=0.
  - On mem_rsp_valid, select the data and extend it per the load type:
    - LB/LBU: byte at addr[1:0].
    - LH/LHU: halfword at addr[1].
    - LW: the full word.
    - Signed types sign-extend; unsigned types zero-extend.
  - The result goes to wb_write_data the next cycle, with wb_write_en = held we && rd!=0. Return to IDLE.
  - Load latency is 1 cycle after mem_rsp_valid.
  - A load to x0 still waits for and consumes the response, without writing.
- Timeout:
  - The counter increments on each WAIT_MEM cycle without a response.
  - When it reaches MEM_TIMEOUT, pulse err_timeout the next cycle, do not write, and return to IDLE.
  - If mem_rsp_valid arrives in the same cycle the counter reaches the limit, the response wins and there is no error.
- mem_rsp_valid in IDLE (late or spurious) is ignored.
- Output timing: wb_write_en, err_misaligned and err_timeout are single-cycle pulses; wb_rd_addr and wb_write_data hold their last value when wb_write_en=0.
- Same-cycle forwarding: the register file forwards write_data to its read ports on a matching rd/rs address when its read enable is high. wb_write_data is therefore registered, and is valid for the whole cycle in which wb_write_en=1.

Test Plan:
- Non-load: accept rd=5, we=1, result=0x1234_5678 -> next cycle wb_write_en=1, rd=5, data=0x1234_5678; with rd=0 -> wb_write_en=0.
- LB: addr=0x1003, rsp=0x80FF_1234 one cycle after acceptance -> write 0xFFFF_FF80. LHU: addr=0x1002, rsp=0x8001_7FFF -> write 0x0000_8001.
- Back-to-back: four non-loads on consecutive cycles -> four consecutive write pulses with matching rd/data. A load then stalls: in_ready=0 until the response cycle.
- Misaligned: LW addr=0x2002 -> err_misaligned pulse, no write, in_ready stays 1. funct3=110 -> same behaviour.
- Timeout: a load with no response for 16 cycles -> err_timeout pulse, no write, in_ready=1. A later stray mem_rsp_valid is ignored. A response in exactly cycle 16 -> normal write, no error.
- Reset mid-WAIT_MEM: assert rst_n=0 for 1 cycle -> IDLE, all outputs 0, in_ready=1. A subsequent response is ignored.
